rr_arb4: RTL
============

Name: rr_arb4

Overview:
- Round-robin arbiter that shares one 4-way one-hot select resource among 4 requesters.
- The grant is held as a 2-bit owner index. The index is expanded to a one-hot grant by an enabled 2-to-4 decoder.
- Each grant is held until the owner releases it, drops its request, or hits a hold-time limit.
- Sits in front of any shared datapath whose select lines are decoder-driven.

Parameters:
- HOLD_MAX, 15, maximum cycles a single grant may be held (1..2^CNT_W-1).
- CNT_W, 4, width of the hold counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  arbiter enable. When low, no new grants are issued and any held grant is dropped.
- req  input  4  request vector, bit k = requester k. Level-sensitive.
- rel  input  1  release pulse from the current owner.
- gnt  output  4  one-hot grant. All-zero when no owner.
- gnt_idx  output  2  index of the current or last owner.
- busy  output  1  high while a grant is held.
- timeout  output  1  one-cycle pulse when a grant was force-released by HOLD_MAX.

Behaviour:
- Reset (async, rst_n=0):
  - gnt=0000, gnt_idx=0, busy=0, timeout=0.
  - Priority pointer ptr=0, hold_cnt=0, state=IDLE.
- States: IDLE, GRANT. All outputs are registered or decoded from registers; there is no combinational path from req to gnt.
- IDLE:
  - If en=1 and req!=0, pick the first set bit searching ptr, ptr+1, ... mod 4 (wrap 3->0).
  - Next cycle: state=GRANT, gnt_idx=k, busy=1, hold_cnt=0. Arbitration latency is 1 cycle.
  - Otherwise stay in IDLE. gnt_idx keeps its last value.
- GRANT, release conditions checked every cycle:
  - (a) rel=1, or (b) req[gnt_idx]=0, or (c) en=0 each cause a normal release.
  - (d) hold_cnt==HOLD_MAX-1 causes a forced release.
  - On any release, next cycle state=IDLE, busy=0, gnt=0000, and ptr=(gnt_idx+1) mod 4.
  - Otherwise hold_cnt increments by 1.
  - A grant therefore lasts at most HOLD_MAX cycles.
- timeout=1 for exactly one cycle, in the first IDLE cycle after a release caused only by (d).
- Simultaneous release conditions:
  - If (d) coincides with (a), (b) or (c), the release is normal and timeout stays 0.
  - Priority among causes is irrelevant otherwise; all give the same next state.
- There is always at least one IDLE cycle between consecutive grants. Back-to-back owners are therefore 2 cycles apart.
- ptr advances only on release, never on an idle cycle. A requester that just released is lowest priority for the next arbitration.
- req changes for non-owners during GRANT are ignored.
- en=0 in IDLE: no grant, ptr unchanged.
- Reset mid-GRANT: immediate return to reset values. No timeout pulse.
- gnt = decode(gnt_idx) gated by busy, so gnt is zero whenever busy=0.

Decomposition:
- Shared package holds:
  - NREQ=4.
  - State encodings IDLE=1'b0, GRANT=1'b1.
  - Default HOLD_MAX.
- Sub-module dec2to4_en (inputs en, a[1:0]; output y[3:0]): combinational enabled decoder driven by busy and gnt_idx.
- The arbiter itself holds the FSM, ptr, hold_cnt and the rotate-and-search logic.

Test Plan:
1. Reset then idle: rst_n=0 for 3 cycles, req=1111 -> gnt=0000, busy=0, timeout=0 throughout reset. First grant after release of reset is gnt=0001 (ptr=0).
2. Round-robin rotation: en=1, req=1111, pulse rel 2 cycles after each grant -> grant order 0001, 0010, 0100, 1000, 0001, each separated by one IDLE cycle with gnt=0000.
3. Wrap and skip: owner 2 releases, then req=0011 -> next gnt=0001 (search 3, 0 hits 0), then ptr=1.
4. Timeout: HOLD_MAX=15, req=0100 held, rel never asserted -> gnt=0100 for exactly 15 cycles, then gnt=0000 with timeout=1 for one cycle, then gnt=0100 again on the next cycle.
5. Simultaneous: rel=1 on the same cycle hold_cnt==14 -> release with timeout=0. Also check: req owner bit drops mid-grant -> gnt=0000 next cycle, ptr advances.
6. Enable and reset mid-grant: en=0 during GRANT -> gnt=0000 next cycle, no new grant while en=0, timeout=0. rst_n pulsed low during GRANT -> gnt=0000 asynchronously, ptr=0.

Source files
------------

// File: rtl/rr_arb4_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
// rr_pick returns the first requester at or after the priority pointer.
package rr_arb4_pkg;

  localparam int NREQ             = 4;
  localparam int HOLD_MAX_DEFAULT = 15;
  localparam int CNT_W_DEFAULT    = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Walk from the farthest rotation back to ptr so the nearest hit wins.
  function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] req,
                                         input logic [1:0]      ptr);
    logic [1:0] pick;
    logic [1:0] k;
    pick = ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = ptr + 2'(i);
      if (req[k]) pick = k;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arb4_dec2to4.sv
// Enabled 2-to-4 one-hot decoder; all outputs are low while en is low.
module dec2to4_en (
  input  logic       en,
  input  logic [1:0] a,
  output logic [3:0] y
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dec
      assign y[gi] = en & (a == 2'(gi));
    end
  endgenerate

endmodule

// File: rtl/rr_arb4.sv
// Round-robin arbiter for four requesters with hold-time limit.
// Owner index is registered; the one-hot grant is decoded from it and gated by busy.
module rr_arb4
  import rr_arb4_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  input  logic            rel,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      gnt_idx,
  output logic            busy,
  output logic            timeout
);

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  logic             rel_norm;
  logic             rel_force;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  // A normal cause coinciding with the hold limit suppresses the timeout pulse.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    to_d      = 1'b0;
    rel_norm  = rel | ~req[idx_q] | ~en;
    rel_force = (cnt_q == CNT_W'(HOLD_MAX - 1));
    case (state_q)
      IDLE: begin
        if (en && (|req)) begin
          state_d = GRANT;
          idx_d   = rr_pick(req, ptr_q);
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (rel_norm || rel_force) begin
          state_d = IDLE;
          ptr_d   = idx_q + 2'd1;
          to_d    = rel_force & ~rel_norm;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == GRANT);
  assign gnt_idx = idx_q;
  assign timeout = to_q;

  dec2to4_en u_dec (
    .en (busy),
    .a  (idx_q),
    .y  (gnt)
  );

endmodule
